reg_bank_arbiter: RTL and testbench
===================================

// Module: reg_bank_arbiter
// PURPOSE
//  Two-requester round-robin arbiter that shares the single-port register bank in reg_access_tlb.
//  Port 0 is the UART command engine; port 1 is a local/debug host.
//  Handles one transaction at a time: accept, strobe the bank, wait out the read latency, return a response.
//  Out-of-range addresses are rejected without touching the bank.
// PARAMETERS
//  ADDR_W    8    request/bank address width
//  DATA_W    8    register data width
//  NUM_REGS  16   implemented registers; valid addresses are 0..NUM_REGS-1
//  RD_LAT    1    bank read latency in cycles from strobe to valid bank_rdata (>=1)
// PORTS
//  clk           in   1       system clock
//  rst           in   1       asynchronous reset, active-high
//  reqN_valid    in   1       N=0,1: request pending
//  reqN_we       in   1       1=write, 0=read
//  reqN_addr     in   ADDR_W  register address
//  reqN_wdata    in   DATA_W  write data
//  reqN_ready    out  1       request accepted this cycle (transfer = valid & ready)
//  reqN_rsp_valid out 1       one-cycle response strobe
//  reqN_rsp_err  out  1       address out of range
//  reqN_rdata    out  DATA_W  read data (0 for writes/errors)
//  bank_en       out  1       bank access strobe
//  bank_we       out  1       bank write enable (qualified by bank_en)
//  bank_addr     out  ADDR_W  bank address
//  bank_wdata    out  DATA_W  bank write data
//  bank_rdata    in   DATA_W  bank read data, valid RD_LAT cycles after a read strobe
// BEHAVIOUR
//  Reset (async): state=IDLE, rr_ptr=0, all outputs 0; an in-flight transaction is dropped, no response.
//  FSM IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE; exactly one transaction in flight.
//  IDLE: reqN_ready is combinational = (state==IDLE) & winner==N & reqN_valid.
//   Winner: only one valid -> that one; both valid -> requester rr_ptr; none -> stay IDLE.
//   On transfer (cycle T): latch owner, we, addr, wdata; go to ISSUE.
//  ISSUE (T+1): if addr<NUM_REGS: bank_en=1, bank_we/addr/wdata from latch; else no strobe, err=1.
//   Write or error -> RESP. Read in range -> WAIT.
//  WAIT: lasts RD_LAT cycles (T+2..T+1+RD_LAT); bank_rdata registered on the last WAIT cycle.
//  RESP: owner's rsp_valid=1 for exactly one cycle with rdata/err; rr_ptr <= ~owner; -> IDLE.
//  Latency: write/error response at T+2; read response at T+2+RD_LAT.
//  Max throughput: one transaction per 3 cycles (write) or 3+RD_LAT cycles (read).
//  Comparison addr<NUM_REGS is done at ADDR_W bits, unsigned; addr==NUM_REGS-1 is valid, addr==NUM_REGS is an error.
//  A requester dropping valid before ready: no effect, nothing latched. Inputs are ignored outside IDLE.
//  Non-owner rsp_valid/rdata/err stay 0; rdata/err are held only during RESP and are 0 otherwise.
//  Back-to-back: a new request can be accepted in the IDLE cycle directly after RESP.
//  Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...
// CONFIGURATION
//  ARB_LOCK_EN defined: adds inputs req0_lock, req1_lock (1 bit, sampled with the transfer).
//   If the accepted request has lock=1, rr_ptr is set to the owner (not ~owner) in RESP.
//   The owner then keeps exclusive grant: the other requester is not granted while the locked owner has not
//   yet issued a lock=0 request. The owner's lock=0 request releases the lock; rr_ptr then advances normally.
//   Reset clears the lock.
//  ARB_LOCK_EN undefined: no lock ports; pure round-robin as above.
// TESTING
//  1. Reset -> all outputs 0; req0 write addr=3 data=0xA5 at T -> bank_en=1/we=1/addr=3/wdata=0xA5 at T+1,
//     req0_rsp_valid=1, err=0 at T+2.
//  2. Bank preloaded reg5=0x3C, RD_LAT=1; req1 read addr=5 -> req1_rsp_valid at T+3, rdata=0x3C, req0 outputs stay 0.
//  3. Both valid from reset, held for 4 transactions -> grant order 0,1,0,1; no cycle with both ready.
//  4. req0 read addr=16 (NUM_REGS=16) -> no bank_en, rsp at T+2 with err=1, rdata=0; addr=15 -> err=0.
//  5. Assert rst during WAIT of a read -> outputs 0 immediately, no rsp_valid, next request starts cleanly.
//  6. ARB_LOCK_EN: req0 lock=1 then lock=0 writes while req1 continuously valid -> req1 granted only after
//     req0's lock=0 response; without the macro, req1 is granted second.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: two-requester round-robin arbiter in front of a single-port
// register bank. One transaction is in flight at a time: accept, strobe the
// bank, wait out the read latency, then return a one-cycle response to the owner.
// Optional feature: define ARB_LOCK_EN to add req0_lock/req1_lock, which let an
// owner keep exclusive grant until it issues a lock=0 request.
module reg_bank_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rsp_valid,
  output logic              req0_rsp_err,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rsp_valid,
  output logic              req1_rsp_err,
  output logic [DATA_W-1:0] req1_rdata,
`ifdef ARB_LOCK_EN
  input  logic              req0_lock,
  input  logic              req1_lock,
`endif
  output logic              bank_en,
  output logic              bank_we,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_wdata,
  input  logic [DATA_W-1:0] bank_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0]  WAIT_LAST    = CNT_W'(RD_LAT - 1);
  // One extra bit so NUM_REGS == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]   NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

  logic [1:0]        state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lock_req_q, lock_req_d;
  logic              lock_active_q, lock_active_d;

  logic winner;
  logic in_range;
  logic issue_hit;
  logic resp0, resp1;
  logic win_lock;

`ifdef ARB_LOCK_EN
  assign win_lock = winner ? req1_lock : req0_lock;
`else
  assign win_lock = 1'b0;
`endif

  // Winner selection: rr_ptr breaks ties; while locked, rr_ptr holds the owner
  // and is the only candidate.
  always_comb begin
    if ((req0_valid && req1_valid) || lock_active_q) winner = rr_ptr_q;
    else if (req1_valid)                             winner = 1'b1;
    else                                             winner = 1'b0;
  end

  assign req0_ready = !rst && (state_q == S_IDLE) && req0_valid && !winner;
  assign req1_ready = !rst && (state_q == S_IDLE) && req1_valid &&  winner;

  assign in_range  = {1'b0, addr_q} < NUM_REGS_EXT;
  assign issue_hit = (state_q == S_ISSUE) && in_range;

  assign bank_en    = issue_hit;
  assign bank_we    = issue_hit && we_q;
  assign bank_addr  = issue_hit ? addr_q  : '0;
  assign bank_wdata = issue_hit ? wdata_q : '0;

  assign resp0 = (state_q == S_RESP) && !owner_q;
  assign resp1 = (state_q == S_RESP) &&  owner_q;

  assign req0_rsp_valid = resp0;
  assign req0_rsp_err   = resp0 && err_q;
  assign req0_rdata     = resp0 ? rdata_q : '0;
  assign req1_rsp_valid = resp1;
  assign req1_rsp_err   = resp1 && err_q;
  assign req1_rdata     = resp1 ? rdata_q : '0;

  // Transaction FSM and request latch: next-state values.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path infers a latch.
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    err_d         = err_q;
    rdata_d       = rdata_q;
    cnt_d         = cnt_q;
    lock_req_d    = lock_req_q;
    lock_active_d = lock_active_q;
    case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          owner_d    = winner;
          we_d       = winner ? req1_we    : req0_we;
          addr_d     = winner ? req1_addr  : req0_addr;
          wdata_d    = winner ? req1_wdata : req0_wdata;
          lock_req_d = win_lock;
          err_d      = 1'b0;
          rdata_d    = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!in_range) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (we_q) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = WAIT_LAST;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = bank_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        lock_active_d = lock_req_q;
        rr_ptr_d      = lock_req_q ? owner_q : !owner_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight transaction and clears the lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= 1'b0;
      owner_q       <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      cnt_q         <= '0;
      lock_req_q    <= 1'b0;
      lock_active_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
      cnt_q         <= cnt_d;
      lock_req_q    <= lock_req_d;
      lock_active_q <= lock_active_d;
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter with a 16-entry, 1-cycle-latency bank model.
// Inputs change and outputs are sampled just after the falling edge.
module tb_reg_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_we, req0_ready, req0_rsp_valid, req0_rsp_err;
  logic [7:0] req0_addr, req0_wdata, req0_rdata;
  logic       req1_valid, req1_we, req1_ready, req1_rsp_valid, req1_rsp_err;
  logic [7:0] req1_addr, req1_wdata, req1_rdata;
`ifdef ARB_LOCK_EN
  logic       req0_lock, req1_lock;
`endif
  logic       bank_en, bank_we;
  logic [7:0] bank_addr, bank_wdata, bank_rdata;
  logic [7:0] mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_bank_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rsp_valid(req0_rsp_valid), .req0_rsp_err(req0_rsp_err),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rsp_valid(req1_rsp_valid), .req1_rsp_err(req1_rsp_err),
    .req1_rdata(req1_rdata),
`ifdef ARB_LOCK_EN
    .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
    .bank_rdata(bank_rdata)
  );

  // Bank model: registered read, one cycle from strobe to data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_rdata <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (bank_en) begin
      if (bank_we) mem[bank_addr[3:0]] <= bank_wdata;
      else         bank_rdata <= mem[bank_addr[3:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready0"}, 32'(req0_ready), 0);
    check({tag, "_ready1"}, 32'(req1_ready), 0);
    check({tag, "_rsp0"},   32'({req0_rsp_valid, req0_rsp_err, req0_rdata}), 0);
    check({tag, "_rsp1"},   32'({req1_rsp_valid, req1_rsp_err, req1_rdata}), 0);
    check({tag, "_bank"},   32'({bank_en, bank_we, bank_addr, bank_wdata}), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
`ifdef ARB_LOCK_EN
    req0_lock = 0; req1_lock = 0;
`endif
    repeat (2) @(negedge clk);
    #1 check_zero("reset");
    rst = 1'b0;

    // 1: req0 write addr 3 = 0xA5; strobe at T+1, response at T+2.
    @(negedge clk);
    req0_valid = 1; req0_we = 1; req0_addr = 8'd3; req0_wdata = 8'hA5;
    #1 check("t1_ready0", 32'(req0_ready), 1);
    check("t1_ready1", 32'(req1_ready), 0);
    @(negedge clk); req0_valid = 0;
    #1 check("t1_bank", 32'({bank_en, bank_we, bank_addr, bank_wdata}), {16'h0, 2'b11, 8'd3, 8'hA5});
    check("t1_rsp_early", 32'(req0_rsp_valid), 0);
    @(negedge clk);
    #1 check("t1_rsp0", 32'({req0_rsp_valid, req0_rsp_err, req0_rdata}), {1'b1, 1'b0, 8'h00});
    check("t1_rsp1_quiet", 32'(req1_rsp_valid), 0);
    check("t1_no_strobe", 32'(bank_en), 0);
    @(negedge clk);
    #1 check("t1_rsp_one_cycle", 32'(req0_rsp_valid), 0);

    // Preload reg5 = 0x3C through requester 1.
    req1_valid = 1; req1_we = 1; req1_addr = 8'd5; req1_wdata = 8'h3C;
    #1 check("pre_ready1", 32'(req1_ready), 1);
    @(negedge clk); req1_valid = 0;
    #1 check("pre_bank", 32'({bank_en, bank_we, bank_addr, bank_wdata}), {16'h0, 2'b11, 8'd5, 8'h3C});
    @(negedge clk);
    #1 check("pre_rsp1", 32'(req1_rsp_valid), 1);
    @(negedge clk);

    // 2: req1 read addr 5 -> response at T+3 with 0x3C.
    req1_valid = 1; req1_we = 0; req1_addr = 8'd5;
    #1 check("t2_ready1", 32'(req1_ready), 1);
    @(negedge clk); req1_valid = 0;
    #1 check("t2_bank", 32'({bank_en, bank_we, bank_addr}), {22'h0, 2'b10, 8'd5});
    @(negedge clk);
    #1 check("t2_wait", 32'(req1_rsp_valid), 0);
    @(negedge clk);
    #1 check("t2_rsp1", 32'({req1_rsp_valid, req1_rsp_err, req1_rdata}), {1'b1, 1'b0, 8'h3C});
    check("t2_rsp0_quiet", 32'({req0_rsp_valid, req0_rsp_err, req0_rdata}), 0);
    @(negedge clk);
    #1 check("t2_rdata_cleared", 32'(req1_rdata), 0);

    // 4: req0 read addr 16 is out of range; addr 15 is the last valid one.
    req0_valid = 1; req0_we = 0; req0_addr = 8'd16;
    #1 check("t4_ready0", 32'(req0_ready), 1);
    @(negedge clk); req0_valid = 0;
    #1 check("t4_no_strobe", 32'(bank_en), 0);
    @(negedge clk);
    #1 check("t4_err_rsp", 32'({req0_rsp_valid, req0_rsp_err, req0_rdata}), {1'b1, 1'b1, 8'h00});
    @(negedge clk);
    #1 check("t4_err_cleared", 32'(req0_rsp_err), 0);
    req0_valid = 1; req0_we = 0; req0_addr = 8'd15;
    @(negedge clk); req0_valid = 0;
    #1 check("t4_bank15", 32'({bank_en, bank_we, bank_addr}), {22'h0, 2'b10, 8'd15});
    @(negedge clk);
    @(negedge clk);
    #1 check("t4_rsp15", 32'({req0_rsp_valid, req0_rsp_err, req0_rdata}), {1'b1, 1'b0, 8'h00});
    @(negedge clk);

    // 5: reset during the WAIT cycle of a read drops the transaction.
    req1_valid = 1; req1_we = 0; req1_addr = 8'd5;
    @(negedge clk); req1_valid = 0;
    @(negedge clk);
    #1 check("t5_in_wait", 32'(req1_rsp_valid), 0);
    rst = 1'b1;
    #1 check_zero("t5_rst");
    @(negedge clk);
    #1 check("t5_no_rsp", 32'({req1_rsp_valid, req0_rsp_valid}), 0);
    rst = 1'b0;
    @(negedge clk);

    // 3: both requesters held valid from reset -> grants 0,1,0,1.
    req0_valid = 1; req0_we = 1; req0_addr = 8'd1; req0_wdata = 8'h11;
    req1_valid = 1; req1_we = 1; req1_addr = 8'd2; req1_wdata = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("t3_grant%0d", i), 32'({req1_ready, req0_ready}), (i % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      #1 check($sformatf("t3_addr%0d", i), 32'(bank_addr), (i % 2 == 0) ? 8'd1 : 8'd2);
      @(negedge clk);
      #1 check($sformatf("t3_rsp%0d", i), 32'({req1_rsp_valid, req0_rsp_valid}), (i % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
    end

    // 6: req0 locked write, then lock=0 write, with req1 continuously valid.
    req0_addr = 8'd7; req0_wdata = 8'h77;
    req1_addr = 8'd8; req1_wdata = 8'h88;
`ifdef ARB_LOCK_EN
    req0_lock = 1;
`endif
    #1 check("t6_grant_a", 32'({req1_ready, req0_ready}), 2'b01);
    @(negedge clk);
    #1 check("t6_addr_a", 32'(bank_addr), 8'd7);
    @(negedge clk);
    #1 check("t6_rsp_a", 32'(req0_rsp_valid), 1);
    req0_addr = 8'd9; req0_wdata = 8'h99;
`ifdef ARB_LOCK_EN
    req0_lock = 0;
`endif
    @(negedge clk);
`ifdef ARB_LOCK_EN
    #1 check("t6_grant_b", 32'({req1_ready, req0_ready}), 2'b01);
    @(negedge clk);
    #1 check("t6_addr_b", 32'(bank_addr), 8'd9);
    @(negedge clk);
    #1 check("t6_rsp_b", 32'({req1_rsp_valid, req0_rsp_valid}), 2'b01);
    @(negedge clk);
    #1 check("t6_grant_c", 32'({req1_ready, req0_ready}), 2'b10);
`else
    #1 check("t6_grant_b", 32'({req1_ready, req0_ready}), 2'b10);
    @(negedge clk);
    #1 check("t6_addr_b", 32'(bank_addr), 8'd8);
    @(negedge clk);
    #1 check("t6_rsp_b", 32'({req1_rsp_valid, req0_rsp_valid}), 2'b10);
    @(negedge clk);
    #1 check("t6_grant_c", 32'({req1_ready, req0_ready}), 2'b01);
`endif
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
